// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: in-order command queue driving registered ALU inputs and capturing results on a valid/ready port.
// Optional define ALU_ISSUE_CNT_EN adds the op_count completed-result counter port.
module alu_issue_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_s,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [3:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic [2:0] res_s,
`ifdef ALU_ISSUE_CNT_EN
    output logic [7:0] op_count,
`endif
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
    state_t state_q, state_d;
    logic [10:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [3:0] alu_a_q, alu_b_q, res_y_q;
    logic [2:0] alu_s_q, res_s_q;
    logic res_valid_q, avail_q;
    logic empty, full, push, pop, res_hs;
`ifdef ALU_ISSUE_CNT_EN
    logic [7:0] op_count_q;
    assign op_count = op_count_q;
`endif
    assign empty = wr_q == rd_q;
    assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign cmd_ready = !full;
    assign push = cmd_valid && !full;
    assign res_hs = res_valid_q && res_ready;
    assign {alu_a, alu_b, alu_s} = {alu_a_q, alu_b_q, alu_s_q};
    assign {res_valid, res_y, res_s} = {res_valid_q, res_y_q, res_s_q};
    assign busy = state_q != IDLE || !empty;
    // avail_q delays queue visibility by one cycle so a fresh push is never popped on its own edge
    always_comb begin
        state_d = state_q;
        pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                pop = avail_q && !empty;
                state_d = pop ? EVAL : IDLE;
            end
            EVAL: state_d = HOLD;
            HOLD: if (res_hs) begin
                pop = avail_q && !empty;
                state_d = pop ? EVAL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {cmd_a, cmd_b, cmd_s};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            avail_q <= 1'b0;
            {alu_a_q, alu_b_q, alu_s_q} <= '0;
            {res_valid_q, res_y_q, res_s_q} <= '0;
`ifdef ALU_ISSUE_CNT_EN
            op_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            avail_q <= !empty;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q <= rd_q + 1'b1;
                {alu_a_q, alu_b_q, alu_s_q} <= mem_q[rd_q[AW-1:0]];
            end
            if (state_q == EVAL) begin
                res_y_q <= alu_y;
                res_s_q <= alu_s_q;
                res_valid_q <= 1'b1;
            end else if (res_hs) begin
                res_valid_q <= 1'b0;
            end
`ifdef ALU_ISSUE_CNT_EN
            if (res_hs) op_count_q <= op_count_q + 8'd1;
`endif
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed tables, corner sequences and randomized traffic against an in-order scoreboard (ALU stub y = a + b).
module tb_alu_issue_ctrl;
    localparam int DEPTH = 2;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic [3:0] y;
    } vec_t;
    logic clk = 0, rst_n = 0, cmd_valid = 0, res_ready = 0;
    logic [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_y, res_y;
    logic [2:0] cmd_s = 0, alu_s, res_s;
    logic cmd_ready, res_valid, busy;
`ifdef ALU_ISSUE_CNT_EN
    logic [7:0] op_count;
`endif
    int vecs = 0, miscompares = 0, n_done = 0;
    vec_t tbl[8];
    vec_t q[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;
    assign alu_y = alu_a + alu_b;

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_s(res_s),
`ifdef ALU_ISSUE_CNT_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({p, "_alu"}, 32'({alu_a, alu_b, alu_s}), 0);
        chk({p, "_res_valid"}, 32'(res_valid), 0);
        chk({p, "_res"}, 32'({res_y, res_s}), 0);
        chk({p, "_busy"}, 32'(busy), 0);
`ifdef ALU_ISSUE_CNT_EN
        chk({p, "_op_count"}, 32'(op_count), 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'($urandom);
            cmd_a = 4'($urandom);
            cmd_b = 4'($urandom);
            cmd_s = 3'($urandom);
            res_ready = 1'($urandom);
            tick();
        end
        chk_zero("rst");
        cmd_valid = 0;
        res_ready = 0;
        rst_n = 1;
        q.delete();
        exp_q.delete();
        n_done = 0;
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        int sum;
        v.a = 4'($urandom);
        v.b = 4'($urandom);
        v.s = 3'($urandom);
        sum = int'(v.a) + int'(v.b);
        v.y = sum[3:0];
        return v;
    endfunction

    // Feeds q into the DUT and scores every result handshake against exp_q in order.
    task automatic drain(input bit rnd, input int max_cyc, input bit spc);
        int cyc = 0, last = -1;
        bit hold;
        logic [3:0] py;
        logic [2:0] ps;
        while ((q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
            cmd_valid = q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0);
            if (q.size() > 0) {cmd_a, cmd_b, cmd_s} = {q[0].a, q[0].b, q[0].s};
            res_ready = !rnd || $urandom_range(0, 2) != 0;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("spurious_result", 32'(res_valid), 0);
                else begin
                    chk("res_y", 32'(res_y), 32'(exp_q[0].y));
                    chk("res_s", 32'(res_s), 32'(exp_q[0].s));
                    void'(exp_q.pop_front());
                    if (spc && last >= 0) chk("spacing", cyc - last, 2);
                    last = cyc;
                    n_done++;
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(q.pop_front());
            hold = res_valid && !res_ready;
            py = res_y;
            ps = res_s;
            tick();
            cyc++;
            if (hold) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_y", 32'(res_y), 32'(py));
                chk("hold_s", 32'(res_s), 32'(ps));
            end
        end
        cmd_valid = 0;
        if (q.size() > 0 || exp_q.size() > 0) begin
            vecs++;
            miscompares++;
            $display("FAIL drain_timeout: %0d commands outstanding, expected 0", q.size() + exp_q.size());
        end
    endtask

    initial begin
        tbl[0] = '{4'h8, 4'h3, 3'd1, 4'hB};
        tbl[1] = '{4'h6, 4'h2, 3'd2, 4'h8};
        tbl[2] = '{4'h9, 4'h2, 3'd3, 4'hB};
        tbl[3] = '{4'h6, 4'h4, 3'd4, 4'hA};
        tbl[4] = '{4'hF, 4'h1, 3'd5, 4'h0};
        tbl[5] = '{4'h7, 4'h7, 3'd7, 4'hE};
        tbl[6] = '{4'h0, 4'h0, 3'd6, 4'h0};
        tbl[7] = '{4'hC, 4'h9, 3'd0, 4'h5};
        do_reset();

        // single command latency
        {cmd_a, cmd_b, cmd_s} = {4'd5, 4'd9, 3'd0};
        cmd_valid = 1;
        res_ready = 1;
        chk("single_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 0;
        tick();
        chk("single_v1", 32'(res_valid), 0);
        chk("single_alu_early", 32'(alu_a), 0);
        tick();
        chk("single_v2", 32'(res_valid), 0);
        chk("single_alu", 32'({alu_a, alu_b, alu_s}), 32'({4'd5, 4'd9, 3'd0}));
        tick();
        chk("single_v3", 32'(res_valid), 1);
        chk("single_y", 32'(res_y), 32'hE);
        chk("single_s", 32'(res_s), 0);
        chk("single_busy", 32'(busy), 1);
        tick();
        n_done++;
        chk("single_done_valid", 32'(res_valid), 0);
        chk("single_done_busy", 32'(busy), 0);

        // back-to-back table
        foreach (tbl[i]) q.push_back(tbl[i]);
        drain(0, 200, 1);

        // backpressure: DEPTH queued plus one held result
        q.push_back('{4'h1, 4'h2, 3'd3, 4'h3});
        q.push_back('{4'h4, 4'h4, 3'd5, 4'h8});
        q.push_back('{4'hF, 4'hF, 3'd6, 4'hE});
        q.push_back('{4'h3, 4'hC, 3'd7, 4'hF});
        res_ready = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = q.size() > 0;
            if (q.size() > 0) {cmd_a, cmd_b, cmd_s} = {q[0].a, q[0].b, q[0].s};
            if (cmd_valid && cmd_ready) exp_q.push_back(q.pop_front());
            tick();
        end
        chk("bp_accepted", exp_q.size(), 3);
        chk("bp_cmd_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_hold_y", 32'(res_y), 32'(exp_q[0].y));
            chk("bp_hold_s", 32'(res_s), 32'(exp_q[0].s));
            tick();
        end
        drain(0, 100, 0);

        // reset while a command is in EVAL with another still queued
        res_ready = 1;
        cmd_valid = 1;
        {cmd_a, cmd_b, cmd_s} = {4'd1, 4'd1, 3'd1};
        tick();
        {cmd_a, cmd_b, cmd_s} = {4'd2, 4'd2, 3'd2};
        tick();
        cmd_valid = 0;
        tick();
        chk("mid_alu_a", 32'(alu_a), 1);
        rst_n = 0;
        #1;
        chk_zero("mid_rst");
        tick();
        rst_n = 1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_valid", 32'(res_valid), 0);
        end
        chk("post_rst_busy", 32'(busy), 0);
        q.push_back('{4'h3, 4'h4, 3'd5, 4'h7});
        drain(0, 50, 0);

        // randomized traffic with random backpressure
        for (int i = 0; i < 200; i++) q.push_back(rnd_vec());
        drain(1, 5000, 0);
        chk("rand_busy", 32'(busy), 0);

`ifdef ALU_ISSUE_CNT_EN
        do_reset();
        for (int i = 0; i < 257; i++) q.push_back(rnd_vec());
        drain(0, 1000, 0);
        chk("op_count_wrap", 32'(op_count), 32'(n_done % 256));
        chk("op_count_257", 32'(op_count), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-issue and result-capture stage wrapped around the team's combinational 4-bit ALU (operands `a`, `b`, select `s`, result `y`). Accepts operand/opcode commands over a valid/ready handshake, buffers them in a small in-order queue, and drives the ALU inputs from registers. It then captures `y` one cycle later and presents it with its opcode tag on a valid/ready result port. It lets a pipelined producer and a stalling consumer share the ALU without glitching its inputs.

## Interface
- `DEPTH`, 2, command queue entries; power of two, 2..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  queue can accept; `!full`.
- `cmd_a`  in  4  operand a.
- `cmd_b`  in  4  operand b.
- `cmd_s`  in  3  ALU select.
- `alu_a`  out  4  registered operand to ALU `a`.
- `alu_b`  out  4  registered operand to ALU `b`.
- `alu_s`  out  3  registered select to ALU `s`.
- `alu_y`  in  4  ALU result `y` (combinational from `alu_a/b/s`).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_y`  out  4  captured result.
- `res_s`  out  3  select that produced `res_y`.
- `busy`  out  1  `state != IDLE || !empty`.
- `op_count`  out  8  completed results (present only with `ALU_ISSUE_CNT_EN`).

## Operation
- Queue: circular FIFO of `{a,b,s}` (11 bits), pointers one bit wider than log2(DEPTH); push on `cmd_valid && cmd_ready`; pop only by FSM.
- A push into a full queue is never accepted, even if a pop occurs in the same cycle. `cmd_ready` is derived from registered occupancy only.
- Push into an empty queue is visible to the FSM the following cycle; there is no bypass.
- FSM states: IDLE, EVAL, HOLD.
  - IDLE: queue non-empty → pop, load `alu_a/b/s`, go EVAL.
  - EVAL: ALU settles; at the edge, `res_y <= alu_y`, `res_s <= alu_s`, `res_valid <= 1`, go HOLD.
  - HOLD: on `res_valid && res_ready`, clear `res_valid`. If the queue is non-empty at that edge, pop, load the ALU regs and go EVAL; else go IDLE.
- `alu_a/b/s` change only on a pop edge; they hold their last value otherwise.
- `res_y/res_s` are stable while `res_valid && !res_ready`.
- Results emerge strictly in command order; no drops, no duplicates.
- Reset (any cycle, including mid-EVAL/HOLD) discards queued and in-flight commands. All outputs go to 0 except `cmd_ready` = 1. The state returns to IDLE.

## Timing
- Reset values: `cmd_ready`=1; `alu_a`=0, `alu_b`=0, `alu_s`=0; `res_valid`=0, `res_y`=0, `res_s`=0; `busy`=0; `op_count`=0.
- Latency: command handshake at edge N → ALU regs loaded at N+2 → `res_valid` high after edge N+3.
- With `res_ready` held at 1, sustained throughput is one result per 2 cycles.
- `res_valid` deasserts at the handshake edge. If another command is queued, the next result is valid 2 edges later.
- Queue capacity: DEPTH queued plus 1 in ALU/result register.

## Configuration
- `ALU_ISSUE_CNT_EN` defined: port `op_count[7:0]` exists. It increments by 1 on each result handshake (`res_valid && res_ready`), wraps 255→0, and resets to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
Bench uses an ALU stub `y = a + b` (mod 16) for all `s`.
- Reset: hold `rst_n`=0 with random inputs → all outputs 0, `cmd_ready`=1, `busy`=0.
- Single command `a`=5, `b`=9, `s`=000, `res_ready`=1 → `res_valid` high 3 edges after the handshake, `res_y`=4'hE, `res_s`=0. `busy` drops after the handshake.
- Back-to-back `{8,3,001}`, `{6,2,010}`, `{9,2,011}`, `{6,4,100}` with `res_ready`=1 → `res_y` = B, 8, B, A in order, with `res_s` = 1, 2, 3, 4. Results are spaced 2 cycles apart.
- Backpressure, DEPTH=2, `res_ready`=0: push 4 commands → the first 3 are accepted and `cmd_ready`=0 during the 4th. `res_y` is held stable. Raising `res_ready` drains all 3 correctly, then accepts the 4th.
- Reset mid-EVAL: assert `rst_n`=0 for one cycle → outputs zero immediately. After release, no stale result appears and the queue is empty.
- With `ALU_ISSUE_CNT_EN`: complete 257 results → `op_count`=1.
